// File: rtl/nts_rx_frame_checker.sv
// nts_rx_frame_checker
//
// Frame-integrity stage between the Ethernet MAC RX stream and the NTS
// dispatcher. Registers the MAC stream (1 cycle latency), checks byte-valid
// framing and frame length, turns malformed/oversize frames into bad-frame
// terminations and keeps four saturating frame counters readable over the
// API bus.
//
// Ports:
//   i_clk, i_areset          clock, asynchronous active-high reset
//   i_mac_rx_*               byte-valid / data / end markers from the MAC
//   o_rx_*                   checked stream towards nts_top (registered)
//   i_api_cs/we/address/
//   i_api_write_data         dispatcher API access
//   o_api_read_data          registered read data, zero when not addressed
//
// API map (offsets from ADDR_BASE): 0 GOOD, 1 BAD, 2 MALFORMED, 3 OVERSIZE,
// 4 CTRL (write bit0=1 clears all counters, reads 0).
module nts_rx_frame_checker #(
    parameter int                        MAC_DATA_WIDTH = 64,
    parameter int                        MAX_WORDS      = 192,
    parameter int                        API_ADDR_WIDTH = 12,
    parameter int                        API_RW_WIDTH   = 32,
    parameter logic [API_ADDR_WIDTH-1:0] ADDR_BASE      = 12'h080
) (
    input  logic                        i_clk,
    input  logic                        i_areset,
    input  logic [MAC_DATA_WIDTH/8-1:0] i_mac_rx_data_valid,
    input  logic [MAC_DATA_WIDTH-1:0]   i_mac_rx_data,
    input  logic                        i_mac_rx_bad_frame,
    input  logic                        i_mac_rx_good_frame,
    output logic [MAC_DATA_WIDTH/8-1:0] o_rx_data_valid,
    output logic [MAC_DATA_WIDTH-1:0]   o_rx_data,
    output logic                        o_rx_bad_frame,
    output logic                        o_rx_good_frame,
    input  logic                        i_api_cs,
    input  logic                        i_api_we,
    input  logic [API_ADDR_WIDTH-1:0]   i_api_address,
    input  logic [API_RW_WIDTH-1:0]     i_api_write_data,
    output logic [API_RW_WIDTH-1:0]     o_api_read_data
);

    localparam int BV = MAC_DATA_WIDTH / 8;
    localparam logic [API_ADDR_WIDTH-1:0] OFS_CTRL = 4;
    localparam int C_GOOD = 0;
    localparam int C_BAD  = 1;
    localparam int C_MAL  = 2;
    localparam int C_OS   = 3;

    typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

    state_t     state_reg, state_eff, state_next;
    logic [7:0] count_reg, count_next;
    logic       partial_reg, partial_next;
    logic       oversize_reg, oversize_next;   // drop reason: 1 oversize, 0 malformed

    logic [BV-1:0] valid_plus1;
    logic          word_present, word_legal, word_full, forward;
    logic          good_end, bad_end;
    logic [3:0]    inc;

    // A legal mask is 0 or a contiguous run of ones from bit 0: adding one
    // to such a mask clears every bit that was set.
    assign valid_plus1  = i_mac_rx_data_valid + {{(BV-1){1'b0}}, 1'b1};
    assign word_present = |i_mac_rx_data_valid;
    assign word_legal   = (valid_plus1 & i_mac_rx_data_valid) == '0;
    assign word_full    = &i_mac_rx_data_valid;

    always_comb begin
        state_eff     = state_reg;
        count_next    = count_reg;
        partial_next  = partial_reg;
        oversize_next = oversize_reg;
        forward       = 1'b0;
        good_end      = 1'b0;
        bad_end       = 1'b0;
        inc           = '0;

        // Word is evaluated first; an end marker in the same cycle then acts
        // on the resulting state.
        if (word_present) begin
            case (state_reg)
                IDLE: begin
                    if (word_legal) begin
                        state_eff    = FRAME;
                        forward      = 1'b1;
                        count_next   = 8'd1;
                        partial_next = !word_full;
                    end else begin
                        state_eff     = DROP;
                        oversize_next = 1'b0;
                    end
                end
                FRAME: begin
                    if (count_reg == 8'(MAX_WORDS)) begin
                        state_eff     = DROP;
                        oversize_next = 1'b1;
                    end else if (partial_reg || !word_legal) begin
                        state_eff     = DROP;
                        oversize_next = 1'b0;
                    end else begin
                        forward      = 1'b1;
                        count_next   = count_reg + 8'd1;
                        partial_next = !word_full;
                    end
                end
                default: ;
            endcase
        end

        state_next = state_eff;
        if (i_mac_rx_good_frame || i_mac_rx_bad_frame) begin
            state_next = IDLE;
            case (state_eff)
                IDLE:  inc[C_MAL] = 1'b1;   // spurious end, nothing emitted
                FRAME: begin
                    if (i_mac_rx_good_frame && !i_mac_rx_bad_frame) begin
                        good_end     = 1'b1;
                        inc[C_GOOD]  = 1'b1;
                    end else begin
                        bad_end      = 1'b1;
                        inc[C_BAD]   = 1'b1;
                    end
                end
                default: begin
                    bad_end = 1'b1;
                    if (oversize_next) inc[C_OS]  = 1'b1;
                    else               inc[C_MAL] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            partial_reg     <= 1'b0;
            oversize_reg    <= 1'b0;
            o_rx_data_valid <= '0;
            o_rx_data       <= '0;
            o_rx_good_frame <= 1'b0;
            o_rx_bad_frame  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            partial_reg     <= partial_next;
            oversize_reg    <= oversize_next;
            o_rx_data_valid <= forward ? i_mac_rx_data_valid : '0;
            o_rx_data       <= forward ? i_mac_rx_data : '0;
            o_rx_good_frame <= good_end;
            o_rx_bad_frame  <= bad_end;
        end
    end

    // ---------------------------------------------------------------- API
    logic [API_ADDR_WIDTH-1:0] api_offset;
    logic                      clear;
    logic [31:0]               cnt_val [4];
    logic                      api_unused;

    assign api_offset = i_api_address - ADDR_BASE;
    assign clear      = i_api_cs && i_api_we && (api_offset == OFS_CTRL) && i_api_write_data[0];
    assign api_unused = ^i_api_write_data[API_RW_WIDTH-1:1];

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [31:0] cnt_reg;
        always_ff @(posedge i_clk or posedge i_areset) begin
            if (i_areset)                        cnt_reg <= '0;
            else if (clear)                      cnt_reg <= '0;   // clear beats increment
            else if (inc[gi] && (cnt_reg != '1)) cnt_reg <= cnt_reg + 32'd1;
        end
        assign cnt_val[gi] = cnt_reg;
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_api_read_data <= '0;
        end else if (i_api_cs && !i_api_we && (api_offset < OFS_CTRL)) begin
            o_api_read_data <= API_RW_WIDTH'(cnt_val[api_offset[1:0]]);
        end else begin
            o_api_read_data <= '0;
        end
    end

endmodule
